// File: rtl/product_accumulator_if.sv
// product_accumulator_if
//   Bundles the two streams of the product accumulator.
//   Product stream: p_in (signed 6-bit product), p_valid, p_ready.
//   Sum stream:     sum_out (signed ACC_W), ovf, sum_valid, sum_ready.
//   master: the side that supplies products and consumes sums.
//   slave:  the accumulator itself.
interface product_accumulator_if #(
  parameter int ACC_W = 8
);
  logic signed [5:0]       p_in;
  logic                    p_valid;
  logic                    p_ready;
  logic signed [ACC_W-1:0] sum_out;
  logic                    sum_valid;
  logic                    sum_ready;
  logic                    ovf;

  modport master (
    output p_in, p_valid, sum_ready,
    input  p_ready, sum_out, sum_valid, ovf
  );

  modport slave (
    input  p_in, p_valid, sum_ready,
    output p_ready, sum_out, sum_valid, ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums groups of COUNT signed products (from a 3x3 signed multiplier) with
//   saturation into a signed ACC_W-bit result, then presents the group sum
//   with a sticky overflow flag until it is accepted downstream.
// Ports:
//   clk    - single clock, rising edge
//   rst_b  - asynchronous active-low reset
//   clr    - synchronous group abort, overrides all handshakes
//   bus    - product_accumulator_if.slave (product in / sum out streams)
//
// state | meaning
// ------+-----------------------------------------------
// ACC   | collecting products, p_ready=1
// HOLD  | sum presented (sum_valid=1), p_ready=sum_ready
module product_accumulator #(
  parameter int ACC_W = 8,
  parameter int COUNT = 16
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  clr,
  product_accumulator_if.slave  bus
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0]        LAST    = CNT_W'(COUNT);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    sticky;
  logic signed [ACC_W-1:0] sum_q;
  logic                    ovf_q;

  logic                    p_ready_c;
  logic                    sum_valid_c;
  logic                    p_hs;
  logic                    s_hs;
  logic                    last_hs;
  logic [ACC_W:0]          sum_wide;
  logic                    clamp;
  logic signed [ACC_W-1:0] sum_sat;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    sticky_inc;

  assign p_hs = bus.p_valid & p_ready_c;
  assign s_hs = sum_valid_c & bus.sum_ready;

  // acc, cnt and sticky are cleared whenever HOLD is entered, so a product
  // accepted in HOLD is naturally added to zero and starts the next group.
  always_comb begin
    sum_wide   = {acc[ACC_W-1], acc} + {{(ACC_W-5){bus.p_in[5]}}, bus.p_in};
    clamp      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum_sat    = sum_wide[ACC_W-1:0];
    if (clamp) begin
      sum_sat = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end
    cnt_inc    = cnt + CNT_W'(1);
    sticky_inc = sticky | clamp;
    last_hs    = p_hs && (cnt_inc == LAST);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ACC;
    end else if (last_hs) begin
      state_nxt = HOLD;
    end else if (s_hs) begin
      state_nxt = ACC;
    end
  end

  always_comb begin
    p_ready_c   = (state == ACC) || bus.sum_ready;
    sum_valid_c = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      sum_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (clr) begin
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      sum_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (p_hs) begin
      if (last_hs) begin
        sum_q  <= sum_sat;
        ovf_q  <= sticky_inc;
        acc    <= '0;
        cnt    <= '0;
        sticky <= 1'b0;
      end else begin
        acc    <= sum_sat;
        cnt    <= cnt_inc;
        sticky <= sticky_inc;
      end
    end
  end

  assign bus.p_ready   = p_ready_c;
  assign bus.sum_valid = sum_valid_c;
  assign bus.sum_out   = sum_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//   Directed bench for product_accumulator: a default instance (ACC_W=8,
//   COUNT=16) and a COUNT=1 instance sharing clock, reset and clr.
//   Inputs change on the falling edge; outputs are observed there too.
module tb_product_accumulator;
  logic clk;
  logic rst_b;
  logic clr;
  int   checks;
  int   failures;

  product_accumulator_if #(.ACC_W(8)) bus ();
  product_accumulator_if #(.ACC_W(8)) bus1 ();

  product_accumulator #(.ACC_W(8), .COUNT(16)) dut (
    .clk(clk), .rst_b(rst_b), .clr(clr), .bus(bus)
  );

  product_accumulator #(.ACC_W(8), .COUNT(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .clr(clr), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input int n, input logic signed [5:0] v);
    for (int i = 0; i < n; i++) begin
      bus.p_valid = 1'b1;
      bus.p_in    = v;
      cycle();
    end
  endtask

  task automatic drain();
    bus.p_valid   = 1'b0;
    bus.sum_ready = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL rst_sum_valid: got %0d expected 0", bus.sum_valid); end
    checks++; if (bus.sum_out !== 8'd0) begin failures++; $display("FAIL rst_sum_out: got %0d expected 0", bus.sum_out); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %0d expected 0", bus.ovf); end
    checks++; if (bus.p_ready !== 1'b1) begin failures++; $display("FAIL rst_p_ready: got %0d expected 1", bus.p_ready); end
    checks++; if (bus1.p_ready !== 1'b1) begin failures++; $display("FAIL rst_p_ready_c1: got %0d expected 1", bus1.p_ready); end
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_basic();
    bus.sum_ready = 1'b1;
    push(15, 6'sd3);
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL basic_early: got %0d expected 0", bus.sum_valid); end
    push(1, 6'sd3);
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %0d expected 1", bus.sum_valid); end
    checks++; if (bus.sum_out !== 8'd48) begin failures++; $display("FAIL basic_sum: got %0d expected 48", bus.sum_out); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %0d expected 0", bus.ovf); end
    checks++; if (bus.p_ready !== 1'b1) begin failures++; $display("FAIL basic_p_ready: got %0d expected 1", bus.p_ready); end
    drain();
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle: got %0d expected 0", bus.sum_valid); end
    checks++; if (bus.p_ready !== 1'b1) begin failures++; $display("FAIL basic_after_ready: got %0d expected 1", bus.p_ready); end
  endtask

  task automatic test_saturation();
    bus.sum_ready = 1'b1;
    push(16, 6'sd16);
    checks++; if (bus.sum_out !== 8'h7F) begin failures++; $display("FAIL sat_pos_sum: got %0d expected 127", bus.sum_out); end
    checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL sat_pos_ovf: got %0d expected 1", bus.ovf); end
    push(16, -6'sd12);
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL sat_neg_valid: got %0d expected 1", bus.sum_valid); end
    checks++; if (bus.sum_out !== 8'h80) begin failures++; $display("FAIL sat_neg_sum: got %0d expected -128", bus.sum_out); end
    checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL sat_neg_ovf: got %0d expected 1", bus.ovf); end
    drain();
  endtask

  task automatic test_bounds();
    bus.sum_ready = 1'b1;
    push(8, 6'sd16);
    push(8, -6'sd12);
    checks++; if (bus.sum_out !== 8'd31) begin failures++; $display("FAIL sticky_sum: got %0d expected 31", bus.sum_out); end
    checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL sticky_ovf: got %0d expected 1", bus.ovf); end
    drain();
    push(7, 6'sd16);
    push(1, 6'sd15);
    push(8, 6'sd0);
    checks++; if (bus.sum_out !== 8'h7F) begin failures++; $display("FAIL exact_max_sum: got %0d expected 127", bus.sum_out); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL exact_max_ovf: got %0d expected 0", bus.ovf); end
    drain();
    push(10, -6'sd12);
    push(1, -6'sd8);
    push(5, 6'sd0);
    checks++; if (bus.sum_out !== 8'h80) begin failures++; $display("FAIL exact_min_sum: got %0d expected -128", bus.sum_out); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL exact_min_ovf: got %0d expected 0", bus.ovf); end
    drain();
  endtask

  task automatic test_back_to_back();
    bus.sum_ready = 1'b0;
    push(16, 6'sd2);
    bus.p_valid = 1'b1;
    bus.p_in    = 6'sd5;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.p_ready !== 1'b0) begin failures++; $display("FAIL stall_p_ready: got %0d expected 0", bus.p_ready); end
      checks++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== 8'd32) begin failures++; $display("FAIL stall_sum: got valid=%0d sum=%0d expected valid=1 sum=32", bus.sum_valid, bus.sum_out); end
      cycle();
    end
    bus.sum_ready = 1'b1;
    #1;
    checks++; if (bus.p_ready !== 1'b1) begin failures++; $display("FAIL release_p_ready: got %0d expected 1", bus.p_ready); end
    cycle();
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid: got %0d expected 0", bus.sum_valid); end
    push(15, 6'sd1);
    checks++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== 8'd20) begin failures++; $display("FAIL b2b_sum: got valid=%0d sum=%0d expected valid=1 sum=20", bus.sum_valid, bus.sum_out); end
    drain();
  endtask

  task automatic test_clr();
    bus.sum_ready = 1'b1;
    push(7, 6'sd3);
    clr = 1'b1;
    push(1, 6'sd3);
    clr = 1'b0;
    checks++; if (bus.sum_valid !== 1'b0 || bus.sum_out !== 8'd0) begin failures++; $display("FAIL clr_out: got valid=%0d sum=%0d expected valid=0 sum=0", bus.sum_valid, bus.sum_out); end
    push(15, 6'sd1);
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL clr_dropped: got %0d expected 0", bus.sum_valid); end
    push(1, 6'sd1);
    checks++; if (bus.sum_out !== 8'd16 || bus.ovf !== 1'b0) begin failures++; $display("FAIL clr_next_sum: got sum=%0d ovf=%0d expected sum=16 ovf=0", bus.sum_out, bus.ovf); end
    bus.p_valid = 1'b0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    checks++; if (bus.sum_valid !== 1'b0 || bus.sum_out !== 8'd0 || bus.ovf !== 1'b0) begin failures++; $display("FAIL clr_hold: got valid=%0d sum=%0d ovf=%0d expected 0 0 0", bus.sum_valid, bus.sum_out, bus.ovf); end
  endtask

  task automatic test_async_reset();
    bus.sum_ready = 1'b0;
    push(16, 6'sd4);
    bus.p_valid = 1'b0;
    checks++; if (bus.sum_valid !== 1'b1 || bus.sum_out !== 8'd64) begin failures++; $display("FAIL ares_pre: got valid=%0d sum=%0d expected valid=1 sum=64", bus.sum_valid, bus.sum_out); end
    #2 rst_b = 1'b0;
    #1;
    checks++; if (bus.sum_valid !== 1'b0 || bus.sum_out !== 8'd0) begin failures++; $display("FAIL ares_out: got valid=%0d sum=%0d expected valid=0 sum=0", bus.sum_valid, bus.sum_out); end
    checks++; if (bus.p_ready !== 1'b1) begin failures++; $display("FAIL ares_p_ready: got %0d expected 1", bus.p_ready); end
    #1 rst_b = 1'b1;
    @(negedge clk);
    bus.sum_ready = 1'b1;
    push(5, 6'sd7);
    bus.p_valid = 1'b0;
    #2 rst_b = 1'b0;
    #2 rst_b = 1'b1;
    @(negedge clk);
    push(15, 6'sd1);
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL ares_mid_early: got %0d expected 0", bus.sum_valid); end
    push(1, 6'sd1);
    checks++; if (bus.sum_out !== 8'd16 || bus.ovf !== 1'b0) begin failures++; $display("FAIL ares_mid_sum: got sum=%0d ovf=%0d expected sum=16 ovf=0", bus.sum_out, bus.ovf); end
    drain();
  endtask

  task automatic test_count1();
    logic [7:0] exp_sum;
    logic signed [5:0] v;
    bus1.sum_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v       = (i % 2 == 0) ? 6'sd16 : -6'sd12;
      exp_sum = (i % 2 == 0) ? 8'h10 : 8'hF4;
      bus1.p_valid = 1'b1;
      bus1.p_in    = v;
      cycle();
      checks++; if (bus1.sum_valid !== 1'b1 || bus1.sum_out !== exp_sum) begin failures++; $display("FAIL c1_sum[%0d]: got valid=%0d sum=%0d expected valid=1 sum=%0d", i, bus1.sum_valid, bus1.sum_out, $signed(exp_sum)); end
      checks++; if (bus1.p_ready !== 1'b1 || bus1.ovf !== 1'b0) begin failures++; $display("FAIL c1_ready[%0d]: got ready=%0d ovf=%0d expected ready=1 ovf=0", i, bus1.p_ready, bus1.ovf); end
    end
    bus1.p_valid = 1'b0;
    cycle();
    checks++; if (bus1.sum_valid !== 1'b0) begin failures++; $display("FAIL c1_end: got %0d expected 0", bus1.sum_valid); end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_b          = 1'b0;
    clr            = 1'b0;
    bus.p_in       = '0;
    bus.p_valid    = 1'b0;
    bus.sum_ready  = 1'b0;
    bus1.p_in      = '0;
    bus1.p_valid   = 1'b0;
    bus1.sum_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_bounds();
    test_back_to_back();
    test_clr();
    test_async_reset();
    test_count1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter ACC_W, default 8, SHALL set the signed accumulator and sum width (legal range 7..32).
REQ-002 Parameter COUNT, default 16, SHALL set the number of products summed per group (legal range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_b  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 clr  input  1  SHALL be the synchronous group abort.
REQ-006 p_in  input  6  SHALL be the signed two's-complement product from the 3x3 signed multiplier (range -12..16).
REQ-007 p_valid  input  1  SHALL qualify p_in.
REQ-008 p_ready  output  1  SHALL indicate the block accepts p_in this cycle.
REQ-009 sum_out  output  ACC_W  SHALL carry the signed group sum.
REQ-010 sum_valid  output  1  SHALL qualify sum_out and ovf.
REQ-011 sum_ready  input  1  SHALL be the downstream acceptance of sum_out.
REQ-012 ovf  output  1  SHALL flag that saturation occurred at least once in the presented group.

Function
REQ-013 The block SHALL have two states: ACC (collecting) and HOLD (sum presented).
REQ-014 A product handshake SHALL occur when p_valid and p_ready are both 1 on a rising edge; a sum handshake when sum_valid and sum_ready are both 1.
REQ-015 p_ready SHALL be 1 in ACC, and in HOLD SHALL equal sum_ready (combinational, no bubble between groups).
REQ-016 sum_valid SHALL be 1 exactly in HOLD; sum_out and ovf SHALL be registered and stable throughout HOLD.
REQ-017 On each product handshake, p_in SHALL be sign-extended to ACC_W and added to the accumulator, and the product counter SHALL increment by 1.
REQ-018 Addition SHALL saturate: results above 2^(ACC_W-1)-1 SHALL clamp to that value, and results below -2^(ACC_W-1) SHALL clamp to that value; any clamp SHALL set the group's sticky overflow bit.
REQ-019 The first product of a group SHALL be added to zero.
REQ-020 When the handshake that brings the counter to COUNT occurs, the block SHALL enter HOLD on that edge, with sum_out equal to the final saturated sum and ovf equal to the group's sticky bit.
REQ-021 In HOLD, a sum handshake without a product handshake SHALL return to ACC with accumulator=0, counter=0, and sticky bit=0.
REQ-022 In HOLD, simultaneous sum and product handshakes SHALL start the next group with accumulator=sext(p_in) and counter=1. With COUNT=1, the block SHALL instead stay in HOLD with sum_out=sext(p_in).
REQ-023 Latency from the last product handshake to sum_valid=1 SHALL be exactly 1 cycle.
REQ-024 clr=1 SHALL override all handshakes: on that edge, state=ACC, accumulator=0, counter=0, sticky=0, sum_valid=0, sum_out=0, ovf=0; the product presented during clr SHALL be dropped.
REQ-025 The counter SHALL be $clog2(COUNT+1) bits wide and SHALL never exceed COUNT.
REQ-026 Inputs SHALL be ignored when their valid is 0; p_in value SHALL not affect state unless a product handshake occurs.

Reset
REQ-027 While rst_b=0, the block SHALL asynchronously set state=ACC, accumulator=0, counter=0, sticky=0, sum_out=0, ovf=0, sum_valid=0.
REQ-028 After reset, p_ready SHALL be 1, and the first accepted product SHALL start a new group.
REQ-029 Reset asserted mid-group or in HOLD SHALL discard the partial or presented sum with no output handshake.

Verification
REQ-030 Defaults, p_valid held 1, p_in=3 for 16 handshakes, sum_ready=1 -> sum_valid=1 for one cycle, sum_out=48, ovf=0; cycle 17 p_ready stays 1.
REQ-031 16 products of +16 -> sum_out=127, ovf=1; next group of 16 products of -12 -> sum_out=-128, ovf=1.
REQ-032 Group completes with sum_ready=0 for 5 cycles -> p_ready=0 and sum_out stable for 5 cycles; the sum handshake and a new product in the same cycle -> the next group counter=1 and accumulator=p_in.
REQ-033 clr pulsed after 7 products (sum 21) with p_valid=1 -> that product is dropped, the next 16 products of +1 sum to 16, ovf=0.
REQ-034 rst_b pulsed low asynchronously between edges during HOLD -> sum_valid falls immediately, sum_out=0, p_ready=1.
REQ-035 COUNT=1, alternating p_in=+16 and -12 with sum_ready=1 -> sum_out follows each product one cycle later with no bubble.
